// File: rtl/encdec_apb_job_driver.sv
// APB initiator for the EncDec register block: takes one job, writes DATA_IN, CODEWORD_WIDTH,
// NOISE and CTRL over APB, then waits for operation_done (or a timeout) and returns one response.
module encdec_apb_job_driver #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BASE_ADDR       = 0,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [1:0]                 job_ctrl,
    input  logic [AMBA_WORD-1:0]       job_data,
    input  logic [1:0]                 job_width,
    input  logic [AMBA_WORD-1:0]       job_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_nof,
    output logic                       rsp_timeout
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL  = AMBA_ADDR_WIDTH'(BASE_ADDR + 32'h0);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA  = AMBA_ADDR_WIDTH'(BASE_ADDR + 32'h4);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH = AMBA_ADDR_WIDTH'(BASE_ADDR + 32'h8);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE = AMBA_ADDR_WIDTH'(BASE_ADDR + 32'hC);

    logic [2:0]                 state_q, state_d;
    logic [1:0]                 idx_q, idx_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [1:0]                 ctrl_q, ctrl_d;
    logic [AMBA_WORD-1:0]       data_q, data_d;
    logic [1:0]                 width_q, width_d;
    logic [AMBA_WORD-1:0]       noise_q, noise_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic                       pwrite_q, pwrite_d;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
    logic                       job_ready_q, job_ready_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic [1:0]                 rsp_nof_q, rsp_nof_d;
    logic                       rsp_timeout_q, rsp_timeout_d;

    // CTRL goes last: writing it starts the slave operation.
    function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    reg_addr = ADDR_DATA;
            2'd1:    reg_addr = ADDR_WIDTH;
            2'd2:    reg_addr = ADDR_NOISE;
            default: reg_addr = ADDR_CTRL;
        endcase
    endfunction

    function automatic logic [AMBA_WORD-1:0] reg_wdata(input logic [1:0] idx, input logic [1:0] ctrl,
                                                      input logic [AMBA_WORD-1:0] data, input logic [1:0] width,
                                                      input logic [AMBA_WORD-1:0] noise);
        case (idx)
            2'd0:    reg_wdata = data;
            2'd1:    reg_wdata = AMBA_WORD'(width);
            2'd2:    reg_wdata = noise;
            default: reg_wdata = AMBA_WORD'(ctrl);
        endcase
    endfunction

    // Next-state, APB bus and response computation.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        ctrl_d        = ctrl_q;
        data_d        = data_q;
        width_d       = width_q;
        noise_d       = noise_q;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        pwrite_d      = 1'b0;
        paddr_d       = '0;
        pwdata_d      = '0;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_nof_d     = rsp_nof_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (job_valid && job_ready_q) begin
                    ctrl_d   = job_ctrl;
                    data_d   = job_data;
                    width_d  = job_width;
                    noise_d  = job_noise;
                    idx_d    = 2'd0;
                    state_d  = ST_SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b1;
                    paddr_d  = reg_addr(2'd0);
                    pwdata_d = reg_wdata(2'd0, job_ctrl, job_data, job_width, job_noise);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                pwrite_d  = 1'b1;
                paddr_d   = paddr_q;
                pwdata_d  = pwdata_q;
            end
            ST_ACCESS: begin
                if (idx_q == 2'd3) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    idx_d    = idx_q + 2'd1;
                    state_d  = ST_SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = 1'b1;
                    paddr_d  = reg_addr(idx_q + 2'd1);
                    pwdata_d = reg_wdata(idx_q + 2'd1, ctrl_q, data_q, width_q, noise_q);
                end
            end
            ST_WAIT: begin
                // Done is checked first so it wins on the timeout edge.
                if (operation_done) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = data_out;
                    rsp_nof_d     = num_of_errors;
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = '0;
                    rsp_nof_d     = 2'd0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        job_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset clears the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= 2'd0;
            cnt_q         <= '0;
            ctrl_q        <= 2'd0;
            data_q        <= '0;
            width_q       <= 2'd0;
            noise_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            job_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_nof_q     <= 2'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            ctrl_q        <= ctrl_d;
            data_q        <= data_d;
            width_q       <= width_d;
            noise_q       <= noise_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            job_ready_q   <= job_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_nof_q     <= rsp_nof_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign job_ready   = job_ready_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_nof     = rsp_nof_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_encdec_apb_job_driver.sv
// Directed bench for encdec_apb_job_driver: write sequence, done/timeout handling,
// back-to-back jobs and asynchronous reset mid-transfer.
module tb_encdec_apb_job_driver;

    localparam int AW = 20;
    localparam int W  = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid;
    logic          job_ready;
    logic [1:0]    job_ctrl;
    logic [W-1:0]  job_data;
    logic [1:0]    job_width;
    logic [W-1:0]  job_noise;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [W-1:0]  PWDATA;
    logic          operation_done;
    logic [DW-1:0] data_out;
    logic [1:0]    num_of_errors;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_nof;
    logic          rsp_timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    encdec_apb_job_driver #(
        .AMBA_ADDR_WIDTH(AW),
        .AMBA_WORD      (W),
        .DATA_WIDTH     (DW),
        .BASE_ADDR      (0),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_ctrl      (job_ctrl),
        .job_data      (job_data),
        .job_width     (job_width),
        .job_noise     (job_noise),
        .PADDR         (PADDR),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PWDATA        (PWDATA),
        .operation_done(operation_done),
        .data_out      (data_out),
        .num_of_errors (num_of_errors),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_nof       (rsp_nof),
        .rsp_timeout   (rsp_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from an IDLE cycle; cycle k is the k-th cycle after the accepting edge T.
    // operation_done is high during cycles done_lo..done_hi; the response is expected in exp_cycle.
    task automatic run_job(input string name, input logic [1:0] ctrl, input logic [31:0] data,
                           input logic [1:0] width, input logic [31:0] noise,
                           input int done_lo, input int done_hi, input logic [31:0] dout,
                           input logic [1:0] nof, input int exp_cycle, input bit exp_to,
                           input bit keep_valid);
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        logic          epen;
        logic [DW-1:0] erd;
        logic [1:0]    enof;
        tests_run++;
        if (job_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_at_start: got %b want 1", name, job_ready);
        end
        job_ctrl  = ctrl;
        job_data  = data;
        job_width = width;
        job_noise = noise;
        job_valid = 1'b1;
        tick();
        job_ctrl  = ~ctrl;
        job_data  = ~data;
        job_width = ~width;
        job_noise = ~noise;
        job_valid = keep_valid;
        erd  = exp_to ? 32'h0 : dout;
        enof = exp_to ? 2'd0 : nof;
        for (int k = 1; k <= exp_cycle + 1; k++) begin
            if (k <= 8) begin
                case ((k - 1) / 2)
                    0:       begin ea = 20'h00004; ed = data;            end
                    1:       begin ea = 20'h00008; ed = {30'd0, width};  end
                    2:       begin ea = 20'h0000C; ed = noise;           end
                    default: begin ea = 20'h00000; ed = {30'd0, ctrl};   end
                endcase
                epen = (k % 2 == 0) ? 1'b1 : 1'b0;
                tests_run++;
                if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, epen, 1'b1, ea, ed}) begin
                    tests_failed++;
                    $display("FAIL %s apb_write k=%0d: got sel=%b en=%b wr=%b addr=%h data=%h want sel=1 en=%b wr=1 addr=%h data=%h",
                             name, k, PSEL, PENABLE, PWRITE, PADDR, PWDATA, epen, ea, ed);
                end
            end else begin
                tests_run++;
                if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b000, 20'h0, 32'h0}) begin
                    tests_failed++;
                    $display("FAIL %s apb_idle k=%0d: got sel=%b en=%b wr=%b addr=%h data=%h want all 0",
                             name, k, PSEL, PENABLE, PWRITE, PADDR, PWDATA);
                end
            end
            tests_run++;
            if (rsp_valid !== ((k == exp_cycle) ? 1'b1 : 1'b0)) begin
                tests_failed++;
                $display("FAIL %s rsp_valid k=%0d: got %b want %b", name, k, rsp_valid, (k == exp_cycle));
            end
            tests_run++;
            if (job_ready !== ((k == exp_cycle + 1) ? 1'b1 : 1'b0)) begin
                tests_failed++;
                $display("FAIL %s job_ready k=%0d: got %b want %b", name, k, job_ready, (k == exp_cycle + 1));
            end
            if (k >= exp_cycle) begin
                tests_run++;
                if ({rsp_timeout, rsp_data, rsp_nof} !== {exp_to, erd, enof}) begin
                    tests_failed++;
                    $display("FAIL %s rsp_fields k=%0d: got to=%b data=%h nof=%0d want to=%b data=%h nof=%0d",
                             name, k, rsp_timeout, rsp_data, rsp_nof, exp_to, erd, enof);
                end
            end
            operation_done = (k >= done_lo && k <= done_hi) ? 1'b1 : 1'b0;
            data_out       = dout;
            num_of_errors  = nof;
            if (k <= exp_cycle) tick();
        end
        operation_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests_run++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_timeout, rsp_data, rsp_nof, job_ready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got sel=%b en=%b wr=%b addr=%h data=%h v=%b to=%b rd=%h nof=%0d rdy=%b want all 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_timeout, rsp_data, rsp_nof, job_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (job_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", job_ready);
        end
    endtask

    task automatic test_basic();
        run_job("basic", 2'b00, 32'h0000_00A5, 2'b00, 32'h0, 12, 12, 32'hDEAD_BEEF, 2'd1, 13, 1'b0, 1'b0);
    endtask

    task automatic test_done_first_wait();
        run_job("done_t9", 2'b01, 32'hCAFE_0001, 2'b01, 32'h0000_0003, 9, 9, 32'h0000_5A5A, 2'd2, 10, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_job("timeout", 2'b10, 32'h1234_5678, 2'b10, 32'h0000_0101, 0, 0, 32'hFFFF_FFFF, 2'd3, 25, 1'b1, 1'b0);
    endtask

    task automatic test_early_done();
        run_job("early_done", 2'b01, 32'h0F0F_0F0F, 2'b01, 32'h8000_0000, 1, 8, 32'hAAAA_5555, 2'd1, 25, 1'b1, 1'b0);
    endtask

    task automatic test_done_on_timeout_edge();
        run_job("done_edge", 2'b10, 32'h7777_0000, 2'b00, 32'h0000_0011, 24, 24, 32'h1357_9BDF, 2'd2, 25, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job("b2b_first", 2'b10, 32'h0000_FFFF, 2'b01, 32'h0000_00F0, 11, 11, 32'h2468_ACE0, 2'd1, 12, 1'b0, 1'b1);
        run_job("b2b_second", 2'b01, 32'hFFFF_0000, 2'b10, 32'hFFFF_FF0F, 10, 10, 32'h0BAD_F00D, 2'd0, 11, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        job_ctrl  = 2'b00;
        job_data  = 32'h0000_0042;
        job_width = 2'b10;
        job_noise = 32'h0000_0000;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        tests_run++;
        if (PSEL !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_active: got sel=%b want 1", PSEL);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, job_ready} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got sel=%b en=%b wr=%b addr=%h data=%h rdy=%b want all 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, job_ready);
        end
        for (int k = 0; k < 3; k++) begin
            operation_done = 1'b1;
            tick();
            tests_run++;
            if ({rsp_valid, PSEL} !== 2'b00) begin
                tests_failed++;
                $display("FAIL rst_mid_hold k=%0d: got v=%b sel=%b want 0 0", k, rsp_valid, PSEL);
            end
        end
        operation_done = 1'b0;
        rst = 1'b0;
        tick();
        run_job("after_rst", 2'b00, 32'h0000_0099, 2'b00, 32'h0000_0001, 14, 14, 32'h0000_0066, 2'd2, 15, 1'b0, 1'b0);
    endtask

    initial begin
        job_valid      = 1'b0;
        job_ctrl       = 2'b00;
        job_data       = 32'h0;
        job_width      = 2'b00;
        job_noise      = 32'h0;
        operation_done = 1'b0;
        data_out       = 32'h0;
        num_of_errors  = 2'd0;
        test_reset();
        test_basic();
        test_done_first_wait();
        test_timeout();
        test_early_done();
        test_done_on_timeout_edge();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
